// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data memory: RV32 size codes,
// controller states and the byte-lane / load-extension helpers.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Narrow store data is replicated across lanes; the byte enables pick the lane.
  function automatic logic [31:0] wdata_align(input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LW:   r = word;
      F3_LBU:  r = {24'd0, b};
      F3_LHU:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    return we ? (f3 > 3'd2) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_banked_if.sv
// Request/response bus between a load-store unit (master) and dmem_banked (slave).
interface dmem_banked_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [2:0]      req_funct3;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_sram.sv
// Word-organised byte-enabled array with a registered synchronous read port.
// Contents are deliberately not reset.
module dmem_sram #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < XLEN/8; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_banked.sv
// Single-outstanding data memory controller: fault checks and store write on
// accept, RD_LAT-cycle load response with sign/zero extension.
//
//   state   | meaning
//   IDLE    | req_ready high, waiting for a request
//   BUSY    | request held; counting down to the response
//   RESP    | rsp_* valid and frozen until rsp_ready
module dmem_banked
  import dmem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LAT      = 1
) (
  input  logic         clk,
  input  logic         rst,
  dmem_banked_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN:0] ADDR_LIMIT = (XLEN+1)'(DEPTH_WORDS * (XLEN/8));
  localparam logic [1:0]    LOAD_CNT   = 2'(RD_LAT - 1);

  state_e          state_q;
  logic [1:0]      cnt_q;
  logic            we_q;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic            err_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic [XLEN-1:0] rsp_rdata_d;

  logic            accept;
  logic            err_now;
  logic [XLEN-1:0] sram_rdata;

  assign accept  = bus.req_valid && req_ready_q;
  assign err_now = is_illegal(bus.req_we, bus.req_funct3)
                || is_misaligned(bus.req_funct3, bus.req_addr[1:0])
                || ({1'b0, bus.req_addr} >= ADDR_LIMIT);

  // Faulting requests never touch the array.
  dmem_sram #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk     (clk),
    .we_i    (accept && bus.req_we && !err_now),
    .re_i    (accept && !bus.req_we && !err_now),
    .be_i    (byte_en(bus.req_funct3, bus.req_addr[1:0])),
    .addr_i  (bus.req_addr[AW+1:2]),
    .wdata_i (wdata_align(bus.req_wdata, bus.req_funct3)),
    .rdata_o (sram_rdata)
  );

  assign rsp_rdata_d = (we_q || err_q) ? '0 : load_extend(sram_rdata, f3_q, off_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      we_q        <= 1'b0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q        <= bus.req_we;
            off_q       <= bus.req_addr[1:0];
            f3_q        <= bus.req_funct3;
            err_q       <= err_now;
            cnt_q       <= bus.req_we ? 2'd0 : LOAD_CNT;
            req_ready_q <= 1'b0;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == 2'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_rdata_q <= rsp_rdata_d;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_banked.sv
// Directed bench for dmem_banked with RD_LAT = 3; expected values are hand-computed.
module tb_dmem_banked;

  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  dmem_banked_if #(.XLEN(32)) bus ();

  dmem_banked #(
    .XLEN        (32),
    .DEPTH_WORDS (256),
    .RD_LAT      (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request; returns at the negedge where the response is first seen.
  // lat counts clock edges from the accept edge to rsp_valid.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                      output int lat);
    int n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("acc_rdy", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    if (bus.rsp_ready) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lt;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    bus.rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy",   {31'd0, bus.req_ready}, 32'd1);
    chk("rst_vld",   {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_err",   {31'd0, bus.rsp_err},   32'd0);
    chk("rst_rdata", bus.rsp_rdata,          32'd0);
    rst = 1'b0;

    xfer(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lt);
    chk("sw_err", {31'd0, er}, 32'd0);
    chk("sw_rd",  rd,          32'd0);
    chk("sw_lat", lt,          32'd1);
    xfer(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lt);
    chk("lw_rd",  rd,          32'hDEADBEEF);
    chk("lw_err", {31'd0, er}, 32'd0);
    chk("lw_lat", lt,          RD_LAT);

    xfer(1'b1, 32'h13, 32'h00000080, 3'b000, rd, er, lt);
    chk("sb_err", {31'd0, er}, 32'd0);
    xfer(1'b0, 32'h13, 32'h0, 3'b000, rd, er, lt);
    chk("lb_13", rd, 32'hFFFFFF80);
    xfer(1'b0, 32'h13, 32'h0, 3'b100, rd, er, lt);
    chk("lbu_13", rd, 32'h00000080);
    xfer(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lt);
    chk("lw_after_sb", rd, 32'h80ADBEEF);
    xfer(1'b0, 32'h12, 32'h0, 3'b001, rd, er, lt);
    chk("lh_12", rd, 32'hFFFF80AD);
    xfer(1'b0, 32'h12, 32'h0, 3'b101, rd, er, lt);
    chk("lhu_12", rd, 32'h000080AD);
    xfer(1'b0, 32'h11, 32'h0, 3'b000, rd, er, lt);
    chk("lb_11", rd, 32'hFFFFFFBE);
    xfer(1'b0, 32'h10, 32'h0, 3'b100, rd, er, lt);
    chk("lbu_10", rd, 32'h000000EF);

    xfer(1'b1, 32'h14, 32'h00000000, 3'b010, rd, er, lt);
    xfer(1'b1, 32'h16, 32'hCAFE1234, 3'b001, rd, er, lt);
    xfer(1'b0, 32'h14, 32'h0, 3'b010, rd, er, lt);
    chk("sh_16", rd, 32'h12340000);

    xfer(1'b0, 32'h12, 32'h0, 3'b010, rd, er, lt);
    chk("lw_mis_err", {31'd0, er}, 32'd1);
    chk("lw_mis_rd",  rd,          32'd0);
    chk("lw_mis_lat", lt,          RD_LAT);
    xfer(1'b1, 32'h11, 32'h0000FFFF, 3'b001, rd, er, lt);
    chk("sh_mis_err", {31'd0, er}, 32'd1);
    chk("sh_mis_rd",  rd,          32'd0);
    xfer(1'b1, 32'h10, 32'hFFFFFFFF, 3'b011, rd, er, lt);
    chk("st_f3_err", {31'd0, er}, 32'd1);
    xfer(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lt);
    chk("lw_unchanged", rd, 32'h80ADBEEF);

    xfer(1'b0, 32'h400, 32'h0, 3'b010, rd, er, lt);
    chk("oor_err", {31'd0, er}, 32'd1);
    chk("oor_rd",  rd,          32'd0);
    chk("oor_lat", lt,          RD_LAT);
    xfer(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lt);
    chk("ld_f3_err", {31'd0, er}, 32'd1);
    xfer(1'b0, 32'h10, 32'h0, 3'b110, rd, er, lt);
    chk("ld_f3_110", {31'd0, er}, 32'd1);
    xfer(1'b1, 32'h3FC, 32'hA5A50001, 3'b010, rd, er, lt);
    chk("top_sw_err", {31'd0, er}, 32'd0);
    xfer(1'b0, 32'h3FC, 32'h0, 3'b010, rd, er, lt);
    chk("top_lw", rd, 32'hA5A50001);
    chk("top_err", {31'd0, er}, 32'd0);

    bus.rsp_ready = 1'b0;
    xfer(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lt);
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_rd",  bus.rsp_rdata,          32'h80ADBEEF);
      chk("hold_err", {31'd0, bus.rsp_err},   32'd0);
      chk("hold_rdy", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rel_vld", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rel_rdy", {31'd0, bus.req_ready}, 32'd1);

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h14;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("busy_rdy", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_rdy", {31'd0, bus.req_ready}, 32'd1);
    rst = 1'b0;
    lt = 0;
    repeat (RD_LAT + 2) begin
      @(negedge clk);
      if (bus.rsp_valid) lt++;
    end
    chk("no_stale_rsp", lt, 32'd0);
    xfer(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lt);
    chk("post_rst_lw", rd, 32'h80ADBEEF);
    chk("post_rst_err", {31'd0, er}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
